// File: rtl/n64adv2_si_cfg_ctrl.sv
// n64adv2_si_cfg_ctrl: picks the Si clock config from video mode, debounces changes and drives the I2C write handshake
module n64adv2_si_cfg_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1024,
  parameter logic [19:0] SETTLE_CYCLES   = 20'd65536,
  parameter logic [19:0] TIMEOUT_CYCLES  = 20'd262143,
  parameter logic [1:0]  MAX_RETRY       = 2'd2
) (
  input  logic       SYS_CLK_i,
  input  logic       SYS_RST_i,
  input  logic       N64_palmode,
  input  logic       lowlatencymode,
  input  logic [2:0] target_resolution,
  output logic       cfg_req_o,
  output logic [3:0] cfg_id_o,
  input  logic       cfg_ack_i,
  input  logic       cfg_fin_i,
  input  logic       cfg_err_i,
  output logic       Si_cfg_done_o,
  output logic       cfg_fail_o
);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, REQ, WAIT, SETTLE, FAIL} state_t;
  state_t      state_q;
  logic        pal_q, ll_q, req_q, done_q, fail_q;
  logic [2:0]  res_q;
  logic [3:0]  want_id, dbid_q, id_q, applied_q;
  logic [15:0] dcnt_q;
  logic [19:0] tcnt_q, scnt_q;
  logic [1:0]  retry_q;
  assign want_id       = ll_q ? {pal_q, 3'b111} : {pal_q, res_q};
  assign cfg_req_o     = req_q;
  assign cfg_id_o      = id_q;
  assign Si_cfg_done_o = done_q;
  assign cfg_fail_o    = fail_q;
  always_ff @(posedge SYS_CLK_i or posedge SYS_RST_i)
    if (SYS_RST_i) {pal_q, ll_q, res_q} <= '0;
    else {pal_q, ll_q, res_q} <= {N64_palmode, lowlatencymode, target_resolution};
  always_ff @(posedge SYS_CLK_i or posedge SYS_RST_i)
    if (SYS_RST_i) begin
      state_q   <= DEBOUNCE;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      id_q      <= 4'h0;
      dbid_q    <= 4'h0;
      applied_q <= 4'hF;
      retry_q   <= 2'd0;
      dcnt_q    <= '0;
      tcnt_q    <= '0;
      scnt_q    <= '0;
    end else
      case (state_q)
        IDLE: if (want_id != applied_q) begin
          state_q <= DEBOUNCE;
          done_q  <= 1'b0;
          dcnt_q  <= '0;
          dbid_q  <= want_id;
        end
        DEBOUNCE: if (want_id != dbid_q) begin
          dcnt_q <= '0;
          dbid_q <= want_id;
        end else if (dcnt_q == DEBOUNCE_CYCLES - 16'd1) begin
          state_q <= REQ;
          req_q   <= 1'b1;
          id_q    <= want_id;
        end else dcnt_q <= dcnt_q + {15'd0, ~&dcnt_q};
        REQ: if (cfg_ack_i) begin
          state_q <= WAIT;
          req_q   <= 1'b0;
          tcnt_q  <= '0;
        end
        WAIT: if (cfg_fin_i && !cfg_err_i) begin
          state_q   <= SETTLE;
          applied_q <= id_q;
          retry_q   <= 2'd0;
          scnt_q    <= '0;
        end else if (cfg_fin_i || tcnt_q == TIMEOUT_CYCLES - 20'd1) begin
          state_q <= retry_q < MAX_RETRY ? REQ : FAIL;
          req_q   <= retry_q < MAX_RETRY;
          fail_q  <= retry_q >= MAX_RETRY;
          retry_q <= retry_q < MAX_RETRY ? retry_q + 2'd1 : retry_q;
        end else tcnt_q <= tcnt_q + {19'd0, ~&tcnt_q};
        SETTLE: if (scnt_q == SETTLE_CYCLES - 20'd1) begin
          state_q <= want_id != applied_q ? DEBOUNCE : IDLE;
          done_q  <= want_id == applied_q;
          dcnt_q  <= '0;
          dbid_q  <= want_id;
        end else scnt_q <= scnt_q + {19'd0, ~&scnt_q};
        FAIL: begin
          req_q  <= 1'b0;
          done_q <= 1'b0;
          fail_q <= 1'b1;
        end
        default: state_q <= DEBOUNCE;
      endcase
endmodule

// File: tb/tb_n64adv2_si_cfg_ctrl.sv
// tb_n64adv2_si_cfg_ctrl: directed checks of power-up, debounce, retry, timeout, settle and reset behaviour
module tb_n64adv2_si_cfg_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       pal = 1'b0, ll = 1'b0, ack = 1'b0, fin = 1'b0, err = 1'b0;
  logic [2:0] res = 3'd2;
  logic       cfg_req_o, Si_cfg_done_o, cfg_fail_o;
  logic [3:0] cfg_id_o;
  int         tests = 0, fails = 0;
  bit         saw_done;
  always #5 clk = ~clk;
  n64adv2_si_cfg_ctrl #(
    .DEBOUNCE_CYCLES(16'd4), .SETTLE_CYCLES(20'd8), .TIMEOUT_CYCLES(20'd32), .MAX_RETRY(2'd2)
  ) dut (
    .SYS_CLK_i(clk), .SYS_RST_i(rst), .N64_palmode(pal), .lowlatencymode(ll),
    .target_resolution(res), .cfg_req_o(cfg_req_o), .cfg_id_o(cfg_id_o),
    .cfg_ack_i(ack), .cfg_fin_i(fin), .cfg_err_i(err),
    .Si_cfg_done_o(Si_cfg_done_o), .cfg_fail_o(cfg_fail_o)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_req(input string tag);
    int n = 0;
    saw_done = 1'b0;
    while (cfg_req_o !== 1'b1 && n < 40) begin
      if (Si_cfg_done_o) saw_done = 1'b1;
      tick;
      n++;
    end
    chk(tag, 32'(cfg_req_o), 32'd1);
  endtask
  task automatic finish_write(input string tag);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk({tag, "_req_drop"}, 32'(cfg_req_o), 32'd0);
    tick;
    fin = 1'b1;
    tick;
    fin = 1'b0;
    repeat (7) tick;
    chk({tag, "_settle7"}, 32'(Si_cfg_done_o), 32'd0);
    tick;
    chk({tag, "_done"}, 32'(Si_cfg_done_o), 32'd1);
  endtask
  initial begin
    repeat (2) tick;
    chk("rst_req", 32'(cfg_req_o), 32'd0);
    chk("rst_id", 32'(cfg_id_o), 32'd0);
    chk("rst_done", 32'(Si_cfg_done_o), 32'd0);
    chk("rst_fail", 32'(cfg_fail_o), 32'd0);
    rst = 1'b0;
    wait_req("pwr_req");
    chk("pwr_id", 32'(cfg_id_o), 32'h2);
    repeat (2) tick;
    chk("pwr_hold_req", 32'(cfg_req_o), 32'd1);
    chk("pwr_hold_id", 32'(cfg_id_o), 32'h2);
    finish_write("pwr");
    res = 3'd4;
    tick;
    chk("chg_idle", 32'(Si_cfg_done_o), 32'd1);
    tick;
    chk("chg_done_drop", 32'(Si_cfg_done_o), 32'd0);
    repeat (3) tick;
    chk("chg_no_req_yet", 32'(cfg_req_o), 32'd0);
    tick;
    chk("chg_req", 32'(cfg_req_o), 32'd1);
    chk("chg_id", 32'(cfg_id_o), 32'h4);
    finish_write("chg");
    res = 3'd5;
    tick;
    tick;
    chk("gl_done_drop", 32'(Si_cfg_done_o), 32'd0);
    res = 3'd4;
    repeat (4) tick;
    chk("gl_restart_a", 32'(cfg_req_o), 32'd0);
    tick;
    chk("gl_restart_b", 32'(cfg_req_o), 32'd0);
    tick;
    chk("gl_req", 32'(cfg_req_o), 32'd1);
    chk("gl_id", 32'(cfg_id_o), 32'h4);
    finish_write("gl");
    res = 3'd1;
    wait_req("to_req");
    chk("to_id", 32'(cfg_id_o), 32'h1);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    repeat (31) tick;
    chk("to_no_retry_yet", 32'(cfg_req_o), 32'd0);
    tick;
    chk("to_retry_req", 32'(cfg_req_o), 32'd1);
    chk("to_retry_id", 32'(cfg_id_o), 32'h1);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    repeat (31) tick;
    fin = 1'b1;
    tick;
    fin = 1'b0;
    chk("to_fin32_no_retry", 32'(cfg_req_o), 32'd0);
    repeat (7) tick;
    chk("to_settle7", 32'(Si_cfg_done_o), 32'd0);
    tick;
    chk("to_done", 32'(Si_cfg_done_o), 32'd1);
    res = 3'd3;
    wait_req("ll_req0");
    ack = 1'b1;
    tick;
    ack = 1'b0;
    fin = 1'b1;
    tick;
    fin = 1'b0;
    repeat (2) tick;
    ll = 1'b1;
    repeat (6) tick;
    chk("ll_settle_end", 32'(Si_cfg_done_o), 32'd0);
    chk("ll_no_abort", 32'(cfg_req_o), 32'd0);
    wait_req("ll_req");
    chk("ll_id", 32'(cfg_id_o), 32'h7);
    chk("ll_no_done", 32'(saw_done), 32'd0);
    finish_write("ll");
    ll = 1'b0;
    res = 3'd6;
    for (int i = 0; i < 3; i++) begin
      wait_req("err_req");
      chk("err_id", 32'(cfg_id_o), 32'h6);
      ack = 1'b1;
      tick;
      ack = 1'b0;
      fin = 1'b1;
      err = 1'b1;
      tick;
      fin = 1'b0;
      err = 1'b0;
    end
    chk("err_fail", 32'(cfg_fail_o), 32'd1);
    chk("err_req_low", 32'(cfg_req_o), 32'd0);
    res = 3'd0;
    repeat (20) tick;
    chk("err_fail_sticky", 32'(cfg_fail_o), 32'd1);
    chk("err_done_low", 32'(Si_cfg_done_o), 32'd0);
    chk("err_no_req", 32'(cfg_req_o), 32'd0);
    res = 3'd5;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rr_fail_clr", 32'(cfg_fail_o), 32'd0);
    wait_req("rr_req");
    chk("rr_id", 32'(cfg_id_o), 32'h5);
    rst = 1'b1;
    #1;
    chk("rr_async_drop", 32'(cfg_req_o), 32'd0);
    tick;
    rst = 1'b0;
    fin = 1'b1;
    tick;
    fin = 1'b0;
    tick;
    chk("rr_late_fin_done", 32'(Si_cfg_done_o), 32'd0);
    chk("rr_late_fin_req", 32'(cfg_req_o), 32'd0);
    wait_req("rr_fresh_req");
    chk("rr_fresh_id", 32'(cfg_id_o), 32'h5);
    finish_write("rr");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
